// File: rtl/sysbus_mem_responder.sv
// Bus-side memory responder: accepts line writes and line reads, returns reads as
// BEATS-long bursts tagged with the captured request tag.
module sysbus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = $clog2(BEATS);

  typedef enum logic [1:0] {StIdle, StWrData, StLat, StResp} state_e;

  state_e                    r_state, w_state_next;
  logic [AW-1:0]             r_index, w_index_next;
  logic [BW-1:0]             r_beat, w_beat_next;
  logic [3:0]                r_cnt, w_cnt_next;
  logic [BUS_TAG_WIDTH-1:0]  r_tag, w_tag_next;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic          w_req_xfer, w_resp_xfer, w_is_read, w_last;
  logic          w_rd_en, w_wr_en;
  logic [AW-1:0] w_rd_addr, w_wr_addr, w_req_index;

  // Byte address -> word index, forced to a line boundary; upper bits wrap.
  assign w_req_index = {bus_req[AW+2:BW+3], {BW{1'b0}}};
  assign w_is_read   = bus_reqtag[BUS_TAG_WIDTH-1];
  assign w_last      = (r_beat == BW'(BEATS - 1));

  assign bus_reqack  = bus_reqcyc && reset && ((r_state == StIdle) || (r_state == StWrData));
  assign w_req_xfer  = bus_reqcyc && bus_reqack;
  assign bus_respcyc = (r_state == StResp);
  assign w_resp_xfer = bus_respcyc && bus_respack;
  assign bus_resp    = r_resp;
  assign bus_resptag = r_tag;

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_beat_next  = r_beat;
    w_cnt_next   = r_cnt;
    w_tag_next   = r_tag;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_index + AW'(r_beat);
    w_wr_en      = 1'b0;
    w_wr_addr    = r_index + AW'(r_beat);
    unique case (r_state)
      StIdle: begin
        if (w_req_xfer) begin
          w_index_next = w_req_index;
          w_beat_next  = '0;
          if (w_is_read) begin
            w_tag_next = bus_reqtag;
            if (READ_LATENCY == 0) begin
              w_state_next = StResp;
              w_rd_en      = 1'b1;
              w_rd_addr    = w_req_index;
            end else begin
              w_state_next = StLat;
              w_cnt_next   = 4'(READ_LATENCY);
            end
          end else begin
            w_state_next = StWrData;
          end
        end
      end
      StWrData: begin
        if (w_req_xfer) begin
          w_wr_en     = 1'b1;
          w_beat_next = r_beat + BW'(1);
          if (w_last) w_state_next = StIdle;
        end
      end
      StLat: begin
        // Fetch beat 0 on the way into StResp so data is ready with respcyc.
        if (r_cnt == 4'd1) begin
          w_state_next = StResp;
          w_rd_en      = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StResp: begin
        if (w_resp_xfer) begin
          w_beat_next = r_beat + BW'(1);
          if (w_last) begin
            w_state_next = StIdle;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_index + AW'(r_beat) + AW'(1);
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_index <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_beat  <= w_beat_next;
      r_cnt   <= w_cnt_next;
      r_tag   <= w_tag_next;
      if (w_rd_en) r_resp <= r_mem[w_rd_addr];
    end
  end

  // Array is deliberately not reset; partially written lines keep their beats.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= bus_req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: two instances (latency 4 and 0) share the
// stimulus; a word-array reference model predicts every read burst.
module tb_sysbus_mem_responder;

  localparam int LAT_A = 4;
  localparam int LAT_B = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        respack = 1'b1;
  bit          sel = 1'b0;

  logic        reqcyc_a, reqcyc_b, ack_a, ack_b, respcyc_a, respcyc_b;
  logic [63:0] resp_a, resp_b;
  logic [12:0] resptag_a, resptag_b;
  logic        ack, respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;

  assign reqcyc_a = reqcyc && !sel;
  assign reqcyc_b = reqcyc && sel;
  assign ack      = sel ? ack_b : ack_a;
  assign respcyc  = sel ? respcyc_b : respcyc_a;
  assign resp     = sel ? resp_b : resp_a;
  assign resptag  = sel ? resptag_b : resptag_a;

  sysbus_mem_responder #(.READ_LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(rst_n), .bus_reqcyc(reqcyc_a), .bus_req(req), .bus_reqtag(reqtag),
    .bus_reqack(ack_a), .bus_respcyc(respcyc_a), .bus_resp(resp_a),
    .bus_resptag(resptag_a), .bus_respack(respack)
  );

  sysbus_mem_responder #(.READ_LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(rst_n), .bus_reqcyc(reqcyc_b), .bus_req(req), .bus_reqtag(reqtag),
    .bus_reqack(ack_b), .bus_respcyc(respcyc_b), .bus_resp(resp_b),
    .bus_resptag(resptag_b), .bus_respack(respack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: flat word array, lines addressed by byte address bits [14:6].
  logic [63:0] model_mem [4096];
  bit          line_ok [512];

  function automatic int unsigned idx_of(input logic [63:0] a);
    return {20'b0, a[14:6], 3'b000};
  endfunction

  logic [63:0] exp_data [$];
  logic [12:0] exp_tag [$];
  int          acc_edge [$];
  int          beat_idx = 0;
  int          last_edge = 0;
  bit          prev_rc = 1'b0;

  // Monitor: compares every presented response beat against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (beat_idx != 0) check("respcyc_mid_burst", 64'(respcyc), 64'd1);
      if (respcyc) begin
        if (exp_data.size() == 0) begin
          check("resp_unexpected", 64'(respcyc), 64'd0);
        end else begin
          if (!prev_rc && acc_edge.size() > 0)
            check("first_beat_latency", 64'(cyc - acc_edge.pop_front()),
                  64'(sel ? LAT_B : LAT_A));
          check("resp_data", resp, exp_data[0]);
          check("resp_tag", 64'(resptag), 64'(exp_tag[0]));
          if (respack) begin
            void'(exp_data.pop_front());
            void'(exp_tag.pop_front());
            beat_idx++;
            if (beat_idx == 8) begin
              beat_idx  = 0;
              last_edge = cyc + 1;
            end
          end
        end
      end
      prev_rc = respcyc;
    end else begin
      prev_rc = 1'b0;
    end
  end

  bit rand_ack = 1'b0;
  bit bp_mode = 1'b0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (bp_mode && beat_idx == 2 && stall_cnt < 3) begin
      respack = 1'b0;
      stall_cnt++;
    end else if (rand_ack) begin
      respack = ($urandom_range(0, 3) != 0);
    end else begin
      respack = 1'b1;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int edge_no);
    bit done;
    done    = 1'b0;
    edge_no = -1;
    reqcyc  = 1'b1;
    req     = d;
    reqtag  = t;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ack) begin
        @(posedge clk);
        #1;
        edge_no = cyc;
        done    = 1'b1;
      end
    end
    check("req_accept", 64'(done), 64'd1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] d [8],
                          input logic [11:0] id, input int nb, output int first_edge);
    int e;
    int acks;
    int unsigned ix;
    ix   = idx_of(addr);
    acks = 0;
    send_beat(addr, {1'b0, id}, e);
    first_edge = e;
    if (e >= 0) acks++;
    for (int k = 0; k < nb; k++) begin
      send_beat(d[k], {1'b0, id}, e);
      if (e >= 0) begin
        acks++;
        model_mem[ix + k] = d[k];
      end
    end
    reqcyc = 1'b0;
    check("write_ack_count", 64'(acks), 64'(nb + 1));
    if (nb == 8) line_ok[ix >> 3] = 1'b1;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag);
    int e;
    int unsigned ix;
    ix = idx_of(addr);
    send_beat(addr, tag, e);
    reqcyc = 1'b0;
    if (e >= 0) begin
      acc_edge.push_back(e);
      for (int k = 0; k < 8; k++) begin
        exp_data.push_back(model_mem[ix + k]);
        exp_tag.push_back(tag);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_data.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_data.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    reqcyc = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_reqack", 64'(ack), 64'd0);
      check("rst_respcyc", 64'(respcyc), 64'd0);
      check("rst_resp", resp, 64'd0);
      check("rst_resptag", 64'(resptag), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    reqcyc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] d [8];
    logic [63:0] pool [8];
    int          e, e2;
    int unsigned ix;

    rst_n  = 1'b0;
    reqcyc = 1'b0;
    req    = '0;
    reqtag = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write line 0x1000, read it back with backpressure at beat 2.
    for (int k = 0; k < 8; k++) d[k] = 64'hA0 + 64'(k);
    do_write(64'h1000, d, 12'h012, 8, e);
    stall_cnt = 0;
    bp_mode   = 1'b1;
    do_read(64'h1000, 13'h1012);
    drain();
    bp_mode = 1'b0;
    check("bp_stalls_seen", 64'(stall_cnt), 64'd3);

    // Unaligned, out-of-range address wraps onto line 0.
    for (int k = 0; k < 8; k++) d[k] = 64'hB0 + 64'(k);
    do_write(64'h8003C, d, 12'h005, 8, e);
    do_read(64'h00038, 13'h1005);
    drain();

    // Reset after 3 data beats leaves a half-new line.
    for (int k = 0; k < 8; k++) d[k] = 64'hC0 + 64'(k);
    do_write(64'h1000, d, 12'h003, 3, e);
    do_reset();
    do_read(64'h1000, 13'h1100);
    drain();

    // Randomised traffic with random response backpressure.
    for (int p = 0; p < 8; p++) pool[p] = {32'($urandom), 32'($urandom)};
    pool[0] = 64'h1000;
    rand_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a;
      a  = pool[$urandom_range(0, 7)];
      ix = idx_of(a);
      if ($urandom_range(0, 2) == 0 || !line_ok[ix >> 3]) begin
        for (int k = 0; k < 8; k++) d[k] = {32'($urandom), 32'($urandom)};
        do_write(a, d, 12'($urandom), 8, e);
      end else begin
        do_read(a, {1'b1, 12'($urandom)});
      end
    end
    drain();
    rand_ack = 1'b0;
    @(posedge clk);
    #1;

    // Zero-latency instance: second request held off until the burst ends.
    sel = 1'b1;
    for (int k = 0; k < 8; k++) d[k] = 64'hD0 + 64'(k);
    do_write(64'h2000, d, 12'h021, 8, e);
    do_read(64'h2000, 13'h1ABC);
    for (int k = 0; k < 8; k++) d[k] = 64'hE0 + 64'(k);
    do_write(64'h3000, d, 12'h777, 8, e2);
    check("busy_ack_edge", 64'(e2), 64'(last_edge + 1));
    do_read(64'h3000, 13'h1777);
    drain();
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Bus-side memory responder: the target end of the system bus that the fetch and memory stages initiate on. It accepts line-sized read and write requests, stores data in an internal word array, and returns read lines as 8-beat bursts tagged with the request tag. It is used as the memory model on the testbench and as the on-chip scratch memory behind the bus arbiter.

Parameters:
BUS_DATA_WIDTH, 64, bus data/address beat width in bits
BUS_TAG_WIDTH, 13, bus tag width
MEM_WORDS, 4096, depth of the internal 64-bit word array; power of 2
READ_LATENCY, 4, idle cycles between read acceptance and first response beat; 0..15
BEATS, 8, beats per line (64-byte line)

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-low reset; 0 = reset
bus_reqcyc  input  1  initiator request valid; held until acked
bus_req  input  BUS_DATA_WIDTH  address beat, then write data beats
bus_reqtag  input  BUS_TAG_WIDTH  [12]=1 read, 0 write; [7:0] transaction id
bus_reqack  output  1  responder accepts the current request beat
bus_respcyc  output  1  response beat valid
bus_resp  output  BUS_DATA_WIDTH  response data beat
bus_resptag  output  BUS_TAG_WIDTH  tag captured from the accepted read request
bus_respack  input  1  initiator consumes the current response beat

Behaviour:
- Beat transfer rules: a request beat transfers on an edge where reqcyc&&reqack. A response beat transfers on an edge where respcyc&&respack.
- bus_reqack is combinational: reqcyc && reset && state in {IDLE, WR_DATA}. Never asserted in LAT or RESP.
- Reset (reset==0 at an edge), including mid-burst:
  - state->IDLE; beat counter and latency counter ->0.
  - bus_respcyc=0, bus_resp=0, bus_resptag=0; bus_reqack=0 while reset is low.
  - Memory array contents are not cleared. A partially written line keeps the beats already written.
- Address: word index = bus_req[log2(MEM_WORDS)+2:3] with low 6 bits forced to 0, i.e. line aligned. Addresses beyond the array wrap modulo MEM_WORDS. Beat k accesses word index+k, k=0..BEATS-1, in order; no critical-word-first.
- IDLE:
  - On a read transfer: capture index and tag. Go to LAT with count=READ_LATENCY; if READ_LATENCY==0, go directly to RESP.
  - On a write transfer: capture index, beat=0, go to WR_DATA.
- WR_DATA: each transfer writes bus_req to word index+beat and increments beat. The transfer with beat==BEATS-1 returns to IDLE. Write tags are not echoed; writes get no response.
- LAT: count decrements each cycle; when count==1 the next state is RESP. First respcyc is therefore high in cycle READ_LATENCY+1 after the acceptance edge.
- RESP:
  - respcyc=1; bus_resp=mem[index+beat]; bus_resptag=captured tag, constant for all beats.
  - Without respack, all outputs hold stable.
  - On a transfer, beat++. Transfer of the last beat -> IDLE with respcyc=0 in the following cycle.
  - Back-to-back: a new request can be acked in the first IDLE cycle.
- Memory read is registered-equivalent: bus_resp is valid in the same cycle as respcyc, with no bubble between beats when respack is held high. Throughput is 1 beat/cycle.
- Read-after-write to the same line returns the written data (write completes before IDLE).
- Requests arriving while busy are not acked and must be held by the initiator.

Test Plan:
- Reset: hold reset=0 with reqcyc=1 for 3 cycles -> reqack=0, respcyc=0, resp=0, resptag=0 throughout.
- Write, then read: write line 0x1000 with data 0xA0..0xA7, tag 0x0012 -> 9 reqack pulses. Then read 0x1000, tag 0x1012, READ_LATENCY=4 -> respcyc rises 5 cycles after the acceptance edge; beats 0xA0..0xA7 on consecutive cycles with respack=1; resptag=0x1012 on all beats.
- Backpressure: during the read, drop respack for 3 cycles at beat 2 -> resp holds 0xA2 and respcyc stays 1; resumes at 0xA3.
- Wrap and alignment: MEM_WORDS=4096; write 0x8003C with 0xB0..0xB7, then read 0x00038 -> returns 0xB0..0xB7 (low 6 bits ignored; address wraps modulo 32 KiB).
- Busy and latency 0: with READ_LATENCY=0, issue a read and present a second reqcyc during RESP -> second request is not acked until the cycle after the last beat. First respcyc is 1 cycle after acceptance.
- Reset mid-write: reset=0 after 3 write data beats -> IDLE; a subsequent read of that line shows the 3 new words and the 5 old words.
